// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the instruction memory
//
// Accepts LEN_HI, LEN_LO, 4*N data bytes (big-endian words) and an XOR checksum
// byte, writes each word to instruction memory at ascending word addresses, and
// releases the CPU once the checksum matches.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   in_valid/ready  byte-stream handshake; in_data is the byte
//   im_we           one-cycle write strobe per assembled word
//   im_addr         word address (holds between writes)
//   im_wdata        assembled word
//   cpu_run         1 = CPU released (core's active-low reset)
//   done / err      load verified / load failed
//   words_loaded    number of words written so far
module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_run,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_len_hi;
    logic [ADDR_W:0]   r_nwords;
    logic [1:0]        r_bcnt;
    logic [23:0]       r_asm;
    logic [7:0]        r_csum;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [ADDR_W:0]   r_words;

    logic              w_accept;
    logic [15:0]       w_len;
    logic              w_oversize;
    logic              w_last_word;

    assign w_accept    = in_valid && in_ready;
    assign w_len       = {r_len_hi, in_data};
    assign w_oversize  = {1'b0, w_len} > MAX_WORDS;
    // r_words doubles as the index of the word being assembled
    assign w_last_word = (r_words + (ADDR_W+1)'(1)) == r_nwords;

    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        cpu_run  = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        case (r_state)
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (w_accept) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    if (w_oversize)      w_next = S_ERR;
                    else if (w_len == 0) w_next = S_CSUM;
                    else                 w_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (w_accept && r_bcnt == 2'd3 && w_last_word) w_next = S_CSUM;
            end
            S_CSUM: begin
                in_ready = 1'b1;
                if (w_accept) w_next = (in_data == r_csum) ? S_RUN : S_ERR;
            end
            S_RUN: begin
                cpu_run = 1'b1;
                done    = 1'b1;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: w_next = S_LEN_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_LEN_HI;
            r_len_hi <= '0;
            r_nwords <= '0;
            r_bcnt   <= '0;
            r_asm    <= '0;
            r_csum   <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_words  <= '0;
        end else begin
            r_state <= w_next;
            r_we    <= 1'b0;
            if (w_accept && r_state != S_CSUM) r_csum <= r_csum ^ in_data;
            if (w_accept) begin
                case (r_state)
                    S_LEN_HI: r_len_hi <= in_data;
                    S_LEN_LO: r_nwords <= w_len[ADDR_W:0];
                    S_DATA: begin
                        r_bcnt <= r_bcnt + 2'd1;
                        r_asm  <= {r_asm[15:0], in_data};
                        if (r_bcnt == 2'd3) begin
                            r_wdata <= {r_asm, in_data};
                            r_addr  <= r_words[ADDR_W-1:0];
                            r_we    <= 1'b1;
                            r_words <= r_words + (ADDR_W+1)'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign im_we        = r_we;
    assign im_addr      = r_addr;
    assign im_wdata     = r_wdata;
    assign words_loaded = r_words;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_run;
    logic              done;
    logic              err;
    logic [ADDR_W:0]   words_loaded;

    int n_cmp = 0;
    int n_bad = 0;

    logic [ADDR_W+31:0] exp_q[$];
    logic [7:0]         tx_q[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .cpu_run(cpu_run), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            logic [ADDR_W+31:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_im_we got addr=%h data=%h required no write", im_addr, im_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({im_addr, im_wdata} !== e) begin
                    n_bad++;
                    $display("FAIL im_write got addr=%h data=%h required addr=%h data=%h",
                             im_addr, im_wdata, e[ADDR_W+31:32], e[31:0]);
                end
            end
            n_cmp++;
            if (cpu_run !== 1'b0) begin
                n_bad++;
                $display("FAIL we_while_run got cpu_run=%b required 0", cpu_run);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_stream(input int max_gap);
        foreach (tx_q[i]) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(1, max_gap)) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_data  = tx_q[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic load_two_word(input logic [7:0] csum);
        tx_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
        tx_q.push_back(csum);
        exp_q.push_back({10'd0, 32'h20080005});
        exp_q.push_back({10'd1, 32'h2009000A});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b required 1", in_ready); end
        n_cmp++; if (im_we !== 1'b0) begin n_bad++; $display("FAIL rst_im_we got %b required 0", im_we); end
        n_cmp++; if (im_addr !== '0) begin n_bad++; $display("FAIL rst_im_addr got %h required 0", im_addr); end
        n_cmp++; if (im_wdata !== '0) begin n_bad++; $display("FAIL rst_im_wdata got %h required 0", im_wdata); end
        n_cmp++; if ({cpu_run, done, err} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got %b required 000", {cpu_run, done, err}); end
        n_cmp++; if (words_loaded !== '0) begin n_bad++; $display("FAIL rst_words got %0d required 0", words_loaded); end
        do_reset();
    endtask

    task automatic check_final(input string name, input logic [2:0] flags, input int words);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({cpu_run, done, err} !== flags) begin n_bad++; $display("FAIL %s_flags got run/done/err=%b required %b", name, {cpu_run, done, err}, flags); end
        n_cmp++; if (words_loaded !== (ADDR_W+1)'(words)) begin n_bad++; $display("FAIL %s_words got %0d required %0d", name, words_loaded, words); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL %s_in_ready got %b required 0", name, in_ready); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL %s_pending_writes got %0d required 0", name, exp_q.size()); end
    endtask

    task automatic test_two_word();
        do_reset();
        load_two_word(8'h0C);
        send_stream(0);
        check_final("two_word", 3'b110, 2);
    endtask

    task automatic test_gaps();
        do_reset();
        load_two_word(8'h0C);
        send_stream(3);
        check_final("gaps", 3'b110, 2);
    endtask

    task automatic test_zero_len();
        do_reset();
        tx_q = '{8'h00, 8'h00, 8'h00};
        send_stream(0);
        check_final("zero_len", 3'b110, 0);
    endtask

    task automatic test_bad_csum();
        do_reset();
        load_two_word(8'h0D);
        send_stream(0);
        check_final("bad_csum", 3'b001, 2);
    endtask

    task automatic test_oversize();
        do_reset();
        tx_q = '{8'h04, 8'h01};
        send_stream(0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oversize_err_immediate got %b required 1", err); end
        check_final("oversize", 3'b001, 0);
    endtask

    task automatic test_max_len();
        logic [7:0]  cs;
        logic [31:0] w;
        do_reset();
        tx_q = '{8'h04, 8'h00};
        cs = 8'h04;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom;
            exp_q.push_back({10'(i), w});
            for (int b = 3; b >= 0; b--) begin
                tx_q.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        tx_q.push_back(cs);
        send_stream(0);
        check_final("max_len", 3'b110, 1024);
        n_cmp++; if (im_addr !== 10'h3FF) begin n_bad++; $display("FAIL max_len_last_addr got %h required 3ff", im_addr); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        tx_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
        exp_q.push_back({10'd0, 32'h20080005});
        send_stream(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready got %b required 1", in_ready); end
        n_cmp++; if (words_loaded !== '0) begin n_bad++; $display("FAIL midrst_words got %0d required 0", words_loaded); end
        n_cmp++; if (cpu_run !== 1'b0) begin n_bad++; $display("FAIL midrst_cpu_run got %b required 0", cpu_run); end
        n_cmp++; if (im_we !== 1'b0) begin n_bad++; $display("FAIL midrst_im_we got %b required 0", im_we); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL midrst_first_word got %0d pending required 0", exp_q.size()); end
        rst = 1'b0;
        load_two_word(8'h0C);
        send_stream(0);
        check_final("after_rst", 3'b110, 2);
    endtask

    initial begin
        test_reset();
        test_two_word();
        test_gaps();
        test_zero_len();
        test_bad_csum();
        test_oversize();
        test_max_len();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle MIPS core's instruction memory.
- Receives a byte stream over a valid/ready interface and assembles big-endian 32-bit words.
- Writes each word into instruction memory at sequential word addresses from 0.
- After the image checksum is verified, releases the CPU from reset. This replaces the simulation-only hex-file preload with a synthesizable path.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; maximum image is 2^ADDR_W words.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input byte valid.
- in_data  in  8  input byte.
- in_ready  out  1  loader can accept a byte this cycle.
- im_we  out  1  instruction-memory write strobe, one-cycle pulse per word.
- im_addr  out  ADDR_W  instruction-memory word address.
- im_wdata  out  32  instruction word to write.
- cpu_run  out  1  1 = CPU released; drives the core's active-low reset directly.
- done  out  1  image loaded and verified.
- err  out  1  load failed (checksum mismatch or oversize length).
- words_loaded  out  ADDR_W+1  count of words written so far.

Behaviour:
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4N data bytes (each word MSB first), then one checksum byte. The checksum is the XOR of every preceding byte, including both length bytes.
- A byte is accepted only on a cycle where in_valid && in_ready. When in_valid=0 the loader holds state; gaps of any length are legal.
- FSM states: S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_RUN, S_ERR.
- in_ready is 1 in S_LEN_HI, S_LEN_LO, S_DATA and S_CSUM. It is 0 in S_RUN and S_ERR.
- S_LEN_HI -> S_LEN_LO on accept.
- S_LEN_LO on accept:
  - N > 2^ADDR_W -> S_ERR.
  - N = 0 -> S_CSUM.
  - otherwise -> S_DATA.
- S_DATA: a 2-bit byte counter shifts bytes into a 32-bit assembly register.
  - On the 4th byte: im_wdata=word and im_addr=current word index are registered, and im_we pulses high in the next cycle only.
  - words_loaded increments in the same cycle as that im_we pulse.
  - After the 4th byte of word N-1 -> S_CSUM. A byte may be accepted in the same cycle as the im_we pulse, so there is no stall between words.
- S_CSUM on accept:
  - byte == running XOR -> S_RUN.
  - otherwise -> S_ERR.
- S_RUN: cpu_run=1, done=1. S_RUN is terminal until rst.
- S_ERR: err=1, cpu_run=0. S_ERR is terminal until rst.
- im_addr holds its last value between writes. im_addr wraps never, because N is bounded by the length check.
- Reset values: in_ready=1 (in S_LEN_HI), im_we=0, im_addr=0, im_wdata=0, cpu_run=0, done=0, err=0, words_loaded=0, checksum accumulator=0, byte counter=0.
- rst at any point, including mid-word or mid-load, returns to S_LEN_HI on the next edge and clears all state and outputs. Any pending im_we is suppressed. cpu_run drops to 0, putting the CPU back in reset. Instruction-memory contents are not cleared.
- The loader never asserts im_we while cpu_run=1.

Test Plan:
- Two-word image: bytes 00 02 20 08 00 05 20 09 00 0A 0C, no gaps -> im_we at addr 0 data 0x20080005, then addr 1 data 0x2009000A. Then done=1, cpu_run=1, words_loaded=2, in_ready=0.
- Same image with in_valid deasserted 1–3 random cycles between bytes -> identical writes and final state; no extra im_we.
- Zero length: 00 00 00 -> no im_we, done=1, cpu_run=1, words_loaded=0.
- Bad checksum: two-word image ending 0x0D -> both words written, err=1, done=0, cpu_run=0, in_ready=0.
- Oversize: 04 01 (N=1025, ADDR_W=10) -> err=1 immediately after LEN_LO, no im_we. Also check N=0x0400 is accepted and addresses reach 0x3FF.
- Reset mid-load: rst asserted after the 6th byte of the two-word image -> next cycle in_ready=1, words_loaded=0, cpu_run=0, no im_we for the partial word. A fresh full stream then loads correctly.
